// File: rtl/mole_game_pkg.sv
// Shared constants for the whack-a-mole scorer: hole count, active-low
// 7-segment digit patterns and the per-mole lock FSM encoding.
package mole_game_pkg;

  localparam int N_HOLES_DEFAULT = 9;

  // Active-low segments, bit0 = a .. bit6 = g, bit7 = DP kept dark.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    ST_ARMED  = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  function automatic logic [7:0] seg7(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One push button: 2-FF synchroniser, stable-level debouncer and a
// single-cycle press strobe on each accepted release-to-pressed change.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      // Any cycle where the input agrees with the accepted level restarts the count.
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_q;

endmodule

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: debounced presses are classified against the lit
// mole, a saturating BCD score is kept and shown on two 7-seg digits.
module mole_hit_scorer
  import mole_game_pkg::*;
#(
  parameter int N_HOLES         = N_HOLES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MISS_PENALTY    = 1
) (
  input  logic               cin,
  input  logic               rst,
  input  logic [N_HOLES-1:0] SW,
  input  logic [N_HOLES-1:0] mole_on,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [3:0]         score_tens,
  output logic [3:0]         score_ones,
  output logic [7:0]         HEX1,
  output logic [7:0]         HEX0,
  output lock_state_t        fsm_state
);

  // hit_pulse / miss_pulse are single-cycle strobes with no backpressure:
  // the sequencer must sample them on the cycle they are high.

  logic [N_HOLES-1:0] press;
  logic [N_HOLES-1:0] mole_prev;

  for (genvar i = 0; i < N_HOLES; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (cin),
      .rst  (rst),
      .raw  (SW[i]),
      .press(press[i])
    );
  end

  logic       lit_press;
  logic       other_press;
  logic       is_hit;
  logic       is_miss;
  logic       mole_changed;
  logic [3:0] inc_tens;
  logic [3:0] inc_ones;
  logic [3:0] dec_tens;
  logic [3:0] dec_ones;

  always_comb begin
    lit_press    = |(press & mole_on);
    other_press  = |(press & ~mole_on);
    mole_changed = (mole_on != mole_prev);
    // A lit press wins over any simultaneous unlit press; a lit press while
    // locked is swallowed, but unlit presses alongside it still count as misses.
    is_hit       = lit_press && (fsm_state == ST_ARMED);
    is_miss      = other_press && !is_hit;

    inc_tens = score_tens;
    inc_ones = score_ones;
    if (!(score_tens == 4'd9 && score_ones == 4'd9)) begin
      if (score_ones == 4'd9) begin
        inc_ones = 4'd0;
        inc_tens = score_tens + 4'd1;
      end else begin
        inc_ones = score_ones + 4'd1;
      end
    end

    dec_tens = score_tens;
    dec_ones = score_ones;
    if (!(score_tens == 4'd0 && score_ones == 4'd0)) begin
      if (score_ones == 4'd0) begin
        dec_ones = 4'd9;
        dec_tens = score_tens - 4'd1;
      end else begin
        dec_ones = score_ones - 4'd1;
      end
    end
  end

  always_ff @(posedge cin) begin
    if (rst) begin
      fsm_state  <= ST_ARMED;
      mole_prev  <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score_tens <= 4'd0;
      score_ones <= 4'd0;
      HEX1       <= SEG_0;
      HEX0       <= SEG_0;
    end else begin
      mole_prev  <= mole_on;
      hit_pulse  <= is_hit;
      miss_pulse <= is_miss;

      // The lock is released by any change of the LED vector, i.e. a new mole.
      case (fsm_state)
        ST_ARMED:  if (is_hit) fsm_state <= ST_LOCKED;
        ST_LOCKED: if (mole_changed) fsm_state <= ST_ARMED;
        default:   fsm_state <= ST_ARMED;
      endcase

      if (is_hit) begin
        score_tens <= inc_tens;
        score_ones <= inc_ones;
      end else if (is_miss && (MISS_PENALTY != 0)) begin
        score_tens <= dec_tens;
        score_ones <= dec_ones;
      end

      HEX1 <= seg7(score_tens);
      HEX0 <= seg7(score_ones);
    end
  end

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Scoreboard bench for mole_hit_scorer: an integer score/lock model predicts
// each press outcome; a negedge monitor checks pulses, score and 7-seg digits.
module tb_mole_hit_scorer;

  localparam int N = 9;
  localparam int D = 4;

  logic       cin = 1'b0;
  logic       rst;
  logic [8:0] SW;
  logic [8:0] mole_on;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [7:0] HEX1;
  logic [7:0] HEX0;
  mole_game_pkg::lock_state_t fsm_state;

  mole_hit_scorer #(
    .N_HOLES(N),
    .DEBOUNCE_CYCLES(D),
    .MISS_PENALTY(1)
  ) dut (
    .cin       (cin),
    .rst       (rst),
    .SW        (SW),
    .mole_on   (mole_on),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse),
    .score_tens(score_tens),
    .score_ones(score_ones),
    .HEX1      (HEX1),
    .HEX0      (HEX0),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 cin = ~cin;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [9:0] exp_q[$];   // {hit, miss, tens, ones}
  int         m_score;
  bit         m_locked;
  logic [8:0] cur_mole;

  logic [7:0] seg_tbl[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  bit         hex_pending = 1'b0;
  logic [7:0] exp_hex1;
  logic [7:0] exp_hex0;
  logic [9:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  always @(negedge cin) begin
    if (rst) begin
      hex_pending = 1'b0;
    end else begin
      if (hex_pending) begin
        check("hex1_decode", HEX1, exp_hex1);
        check("hex0_decode", HEX0, exp_hex0);
        hex_pending = 1'b0;
      end
      if (hit_pulse || miss_pulse) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("FAIL unexpected_pulse: got hit=%0b miss=%0b, expected no pulse (t=%0t)",
                   hit_pulse, miss_pulse, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("event", {hit_pulse, miss_pulse, score_tens, score_ones}, mon_e);
          exp_hex1    = seg_tbl[mon_e[7:4]];
          exp_hex0    = seg_tbl[mon_e[3:0]];
          hex_pending = 1'b1;
        end
      end
    end
  end

  // reference model: game rules on an integer score
  task automatic model_press(input logic [8:0] mask, output bit ev);
    bit lit   = |(mask & cur_mole);
    bit other = |(mask & ~cur_mole);
    ev = 1'b0;
    if (lit && !m_locked) begin
      m_locked = 1'b1;
      m_score  = (m_score < 99) ? m_score + 1 : 99;
      exp_q.push_back({2'b10, 4'(m_score / 10), 4'(m_score % 10)});
      ev = 1'b1;
    end else if (other) begin
      m_score = (m_score > 0) ? m_score - 1 : 0;
      exp_q.push_back({2'b01, 4'(m_score / 10), 4'(m_score % 10)});
      ev = 1'b1;
    end
  endtask

  // driver tasks
  task automatic set_mole(input logic [8:0] m);
    @(posedge cin); #1;
    if (m != cur_mole) m_locked = 1'b0;
    cur_mole = m;
    mole_on  = m;
    repeat (2) @(posedge cin);
  endtask

  task automatic press(input logic [8:0] mask, output int lat);
    bit ev;
    model_press(mask, ev);
    lat = -1;
    @(posedge cin); #1;
    SW = mask;
    for (int c = 1; c <= 12; c++) begin
      @(posedge cin); #1;
      if (lat < 0 && (hit_pulse || miss_pulse)) lat = c;
    end
    SW = '0;
    repeat (D + 8) @(posedge cin);
    #1;
    check("press_latency", lat, ev ? 7 : -1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic hit_next();
    int h;
    int lat;
    logic [8:0] one = 9'd1;
    logic [8:0] m;
    h = $urandom_range(0, N - 1);
    m = one << h;
    if (m == cur_mole) m = one << ((h + 1) % N);
    set_mole(m);
    press(m, lat);
  endtask

  task automatic miss_next();
    int lat;
    logic [8:0] one = 9'd1;
    set_mole(9'h000);
    press(one << $urandom_range(0, N - 1), lat);
  endtask

  task automatic bounce_hole5();
    int seen = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge cin); #1;
      if (c % 2 == 0) SW[5] = ~SW[5];
      if (hit_pulse || miss_pulse) seen++;
    end
    SW = '0;
    repeat (D + 8) begin
      @(posedge cin); #1;
      if (hit_pulse || miss_pulse) seen++;
    end
    check("bounce_pulses", seen, 0);
  endtask

  task automatic random_txn();
    int r;
    int lat;
    int h1;
    int h2;
    logic [8:0] one = 9'd1;
    logic [8:0] m;
    logic [8:0] mask;
    r = $urandom_range(0, 99);
    if (r < 25) m = cur_mole;
    else if (r < 40) m = 9'h000;
    else m = one << $urandom_range(0, N - 1);
    set_mole(m);
    r  = $urandom_range(0, 99);
    h1 = $urandom_range(0, N - 1);
    h2 = (h1 + $urandom_range(1, N - 1)) % N;
    if (r < 25 && cur_mole != 0) mask = cur_mole;
    else if (r < 85) mask = one << h1;
    else mask = (one << h1) | (one << h2);
    press(mask, lat);
  endtask

  initial begin
    int lat;
    SW       = '0;
    mole_on  = '0;
    cur_mole = '0;
    m_score  = 0;
    m_locked = 1'b0;
    rst      = 1'b1;

    // reset values
    repeat (2) @(posedge cin);
    #1;
    check("reset_hex0", HEX0, 8'hC0);
    check("reset_hex1", HEX1, 8'hC0);
    check("reset_score", {score_tens, score_ones}, 8'h00);
    check("reset_pulses", {hit_pulse, miss_pulse}, 2'b00);
    rst = 1'b0;

    // first hit and its latency
    set_mole(9'h004);
    press(9'h004, lat);
    check("first_hit_latency", lat, 7);
    check("score_after_hit", {score_tens, score_ones}, 8'h01);
    check("hex0_after_hit", HEX0, 8'hF9);

    // lock: re-press on the same mole is ignored, new mole re-arms
    press(9'h004, lat);
    check("locked_score", {score_tens, score_ones}, 8'h01);
    set_mole(9'h008);
    press(9'h008, lat);
    check("rearmed_score", {score_tens, score_ones}, 8'h02);

    // miss with penalty, then a bouncing button
    set_mole(9'h001);
    press(9'h020, lat);
    check("miss_score", {score_tens, score_ones}, 8'h01);
    bounce_hole5();

    // carry, upper and lower saturation
    while (m_score < 9) hit_next();
    hit_next();
    check("carry_score", {score_tens, score_ones}, 8'h10);
    check("carry_hex1", HEX1, 8'hF9);
    check("carry_hex0", HEX0, 8'hC0);
    while (m_score < 99) hit_next();
    hit_next();
    check("sat_high_score", {score_tens, score_ones}, 8'h99);
    while (m_score > 0) miss_next();
    miss_next();
    check("sat_low_score", {score_tens, score_ones}, 8'h00);

    // simultaneous presses: one hit, no miss
    set_mole(9'h010);
    press(9'h011, lat);
    check("simul_score", {score_tens, score_ones}, 8'h01);

    repeat (60) random_txn();

    // reset in the middle of a debounce
    @(posedge cin); #1;
    SW = 9'h002;
    repeat (4) @(posedge cin);
    #1;
    rst = 1'b1;
    SW  = '0;
    @(posedge cin); #1;
    rst      = 1'b0;
    m_score  = 0;
    m_locked = 1'b0;
    repeat (D + 12) @(posedge cin);
    #1;
    check("rst_mid_score", {score_tens, score_ones}, 8'h00);
    check("rst_mid_hex0", HEX0, 8'hC0);
    check("rst_mid_hex1", HEX1, 8'hC0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
